// File: rtl/pw_accum_pkg.sv
// Shared types and widths for the pointwise-conv accumulate sequencer.
package pw_accum_pkg;

   localparam int MAX_GRP_DEF = 64;
   localparam int FIFO_D_DEF  = 4;
   localparam int GRP_W       = $clog2(MAX_GRP_DEF + 1);
   localparam int FIFO_AW     = $clog2(FIFO_D_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   typedef struct packed {
      logic v;
      logic last;
   } tag_t;

endpackage

// File: rtl/acc_result_fifo.sv
// Synchronous first-word-fall-through result FIFO with occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module acc_result_fifo #(
   parameter int W  = 48,
   parameter int D  = 4,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign do_push = push_i && (cnt_q != (AW+1)'(D));
   assign do_pop  = pop_i && (cnt_q != '0);
   assign head_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < D; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         // simultaneous push and pop leaves the count unchanged
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/pw_accum_sequencer.sv
// Issues product vectors to the adder tree, accumulates cfg_groups tree sums per output, returns results via a credit-guarded FIFO.
// Optional ACC_SAT_EN: saturating accumulate plus sticky ovf output; default build wraps.
module pw_accum_sequencer
   import pw_accum_pkg::*;
#(
   parameter int PAR      = 16,
   parameter int ACC_W    = 48,
   parameter int TREE_LAT = 5,
   parameter int MAX_GRP  = MAX_GRP_DEF,
   parameter int OUT_W    = 16,
   parameter int FIFO_D   = FIFO_D_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [GRP_W-1:0]        cfg_groups,
   input  logic [OUT_W-1:0]        cfg_outputs,
   output logic                    busy,
   output logic                    done,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic                    tree_valid,
   input  logic signed [ACC_W-1:0] tree_sum,
   input  logic                    tree_vout,
   output logic signed [ACC_W-1:0] m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    err
`ifdef ACC_SAT_EN
   ,output logic                   ovf
`endif
);

   if (PAR < 1 || TREE_LAT < 1 || MAX_GRP >= (1 << GRP_W) || FIFO_D != (1 << FIFO_AW)) begin : g_bad_cfg
      $error("pw_accum_sequencer: parameter set does not match package widths");
   end

   localparam int LW = $clog2(TREE_LAT + 1);

   state_t                  state_q;
   logic                    busy_q, done_q, err_q, err_d;
   logic                    acc_vld_q, acc_vld_d;
   logic [GRP_W-1:0]        grp_cfg_q, grp_q;
   logic [OUT_W-1:0]        out_cfg_q, out_q;
   tag_t                    tag_q [TREE_LAT];
   tag_t                    tag_out;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [FIFO_AW:0]        fifo_cnt;
   logic                    fifo_empty, push, pop, hs;
   logic                    grp_last, out_last, pipe_busy, credit_ok;
   logic [LW-1:0]           last_inflight;

   assign grp_last = (grp_q == grp_cfg_q - GRP_W'(1));
   assign out_last = (out_q == out_cfg_q - OUT_W'(1));
   assign tag_out  = tag_q[TREE_LAT-1];

   always_comb begin
      last_inflight = '0;
      pipe_busy     = 1'b0;
      for (int i = 0; i < TREE_LAT; i++) begin
         last_inflight = last_inflight + LW'(tag_q[i].v & tag_q[i].last);
         pipe_busy     = pipe_busy | tag_q[i].v;
      end
   end

   // Every last-group tag in flight owns a FIFO slot, so the FIFO can never overflow.
   assign credit_ok  = (int'(fifo_cnt) + int'(last_inflight)) < FIFO_D;
   assign s_ready    = (state_q == RUN) && (!grp_last || credit_ok);
   assign hs         = s_valid && s_ready;
   assign tree_valid = hs;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign m_valid    = !fifo_empty;
   assign pop        = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         grp_cfg_q <= '0;
         out_cfg_q <= '0;
         grp_q     <= '0;
         out_q     <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (start) begin
               grp_cfg_q <= cfg_groups;
               out_cfg_q <= cfg_outputs;
               grp_q     <= '0;
               out_q     <= '0;
               busy_q    <= 1'b1;
               state_q   <= (cfg_groups == '0 || cfg_outputs == '0) ? FIN : RUN;
            end
            RUN: if (hs) begin
               if (grp_last) begin
                  grp_q <= '0;
                  if (out_last) state_q <= DRAIN;
                  else          out_q   <= out_q + OUT_W'(1);
               end else begin
                  grp_q <= grp_q + GRP_W'(1);
               end
            end
            DRAIN: if (!pipe_busy && !acc_vld_q && fifo_empty) state_q <= FIN;
            FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag stage TREE_LAT-1 lines up with the tree's valid_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TREE_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{v: hs, last: hs & grp_last};
         for (int i = 1; i < TREE_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

`ifdef ACC_SAT_EN
   logic signed [ACC_W:0] sum_x;
   logic                  clip;
   logic                  ovf_q;

   always_comb begin
      sum_x = {acc_q[ACC_W-1], acc_q} + {tree_sum[ACC_W-1], tree_sum};
      clip  = (sum_x[ACC_W] != sum_x[ACC_W-1]);
      if (!clip)             acc_sum = sum_x[ACC_W-1:0];
      else if (sum_x[ACC_W]) acc_sum = {1'b1, {(ACC_W-1){1'b0}}};
      else                   acc_sum = {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (rst)                            ovf_q <= 1'b0;
      else if (state_q == IDLE && start)  ovf_q <= 1'b0;
      else if (tree_vout && clip)         ovf_q <= 1'b1;
   end
   assign ovf = ovf_q;
`else
   assign acc_sum = acc_q + tree_sum;
`endif

   always_comb begin
      acc_d     = acc_q;
      acc_vld_d = acc_vld_q;
      push      = 1'b0;
      err_d     = err_q | (tree_vout != tag_out.v);
      if (tree_vout) begin
         if (tag_out.last) begin
            push      = 1'b1;
            acc_d     = '0;
            acc_vld_d = 1'b0;
         end else begin
            acc_d     = acc_sum;
            acc_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         acc_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         acc_vld_q <= acc_vld_d;
         err_q     <= err_d;
      end
   end

   acc_result_fifo #(
      .W  (ACC_W),
      .D  (FIFO_D),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (acc_sum),
      .pop_i      (pop),
      .head_o     (m_data),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt)
   );

endmodule
